// File: rtl/ultrasensor_emulator.sv
// ultrasensor_emulator
// Synthesizable stand-in for an HC-SR04 ultrasonic sensor. It is the
// responder side of the trigger/echo handshake. A trigger pulse of at least
// TRIG_MIN_CYCLES is accepted. After a fixed burst delay, an echo pulse is
// driven whose width encodes the programmed obstacle distance. A hold-off
// period follows, during which further triggers are ignored.
//
// Ports
//   clk              in   1   system clock
//   reset            in   1   synchronous, active-high
//   enable           in   1   0 forces the FSM back to IDLE (synchronous)
//   trigger          in   1   trigger from the controller, may be asynchronous
//   obstacle_present in   1   1: echo width = echo_width, 0: echo width = timeout
//   echo_width       in   W   obstacle echo width in clk cycles
//   echo             out  1   echo pulse to the controller, registered
//   busy             out  1   high whenever the FSM is not IDLE, registered
//   short_trig       out  1   single-cycle pulse, trigger rejected as too short

module ultrasensor_emulator #(
  parameter int W                   = 23,
  parameter int TRIG_MIN_CYCLES     = 1000,
  parameter int BURST_DELAY_CYCLES  = 20000,
  parameter int ECHO_TIMEOUT_CYCLES = 3800000,
  parameter int HOLDOFF_CYCLES      = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         trigger,
  input  logic         obstacle_present,
  input  logic [W-1:0] echo_width,
  output logic         echo,
  output logic         busy,
  output logic         short_trig
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG_HI = 3'd1;
  localparam logic [2:0] S_BURST   = 3'd2;
  localparam logic [2:0] S_ECHO_HI = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  localparam logic [W-1:0] TRIG_MIN = W'(TRIG_MIN_CYCLES);
  localparam logic [W-1:0] BURST_DELAY = W'(BURST_DELAY_CYCLES);
  localparam logic [W-1:0] ECHO_TIMEOUT = W'(ECHO_TIMEOUT_CYCLES);
  localparam logic [W-1:0] HOLDOFF = W'(HOLDOFF_CYCLES);
  localparam logic [W-1:0] ONE = W'(1);

  logic [2:0]   state;
  logic         trig_meta;
  logic         trig_s;
  logic         trig_d;
  logic         trig_rise;
  logic [W-1:0] tcnt;
  logic [W-1:0] dcnt;
  logic [W-1:0] ecnt;
  logic [W-1:0] hcnt;
  logic [W-1:0] wreg;
  logic [W-1:0] width_cap;

  // Two-flop synchronizer plus a delayed copy for edge detection. These flops
  // are deliberately left out of reset so they keep tracking the pin. As a
  // result, a trigger held high across reset or enable=0 shows no rising edge
  // once the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    trig_meta <= trigger;
    trig_s    <= trig_meta;
    trig_d    <= trig_s;
  end

  assign trig_rise = trig_s & ~trig_d;

  // Echo width captured when a trigger is accepted. The width is clamped to
  // the timeout. A zero width is widened to one cycle so an echo pulse
  // always appears.
  always_comb begin
    width_cap = ECHO_TIMEOUT;
    if (obstacle_present) begin
      if (echo_width > ECHO_TIMEOUT) begin
        width_cap = ECHO_TIMEOUT;
      end else if (echo_width == '0) begin
        width_cap = ONE;
      end else begin
        width_cap = echo_width;
      end
    end
  end

  // Main protocol FSM.
  // tcnt: trigger high time, saturating at the minimum.
  // dcnt: burst delay counter.
  // ecnt: echo high time counter.
  // hcnt: hold-off time counter.
  // ecnt and hcnt both start at 1 on entry to their state. A compare against
  // the target then gives exactly target cycles in that state.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= S_IDLE;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
      tcnt       <= '0;
      dcnt       <= '0;
      ecnt       <= '0;
      hcnt       <= '0;
      wreg       <= '0;
    end else begin
      short_trig <= 1'b0;
      case (state)
        S_IDLE: begin
          echo <= 1'b0;
          busy <= 1'b0;
          if (trig_rise) begin
            state <= S_TRIG_HI;
            tcnt  <= ONE;
            busy  <= 1'b1;
          end
        end

        S_TRIG_HI: begin
          if (trig_s) begin
            if (tcnt < TRIG_MIN) begin
              tcnt <= tcnt + ONE;
            end
          end else if (tcnt >= TRIG_MIN) begin
            wreg  <= width_cap;
            dcnt  <= '0;
            tcnt  <= '0;
            state <= S_BURST;
          end else begin
            short_trig <= 1'b1;
            busy       <= 1'b0;
            tcnt       <= '0;
            state      <= S_IDLE;
          end
        end

        // dcnt reaches BURST_DELAY after BURST_DELAY cycles in this state.
        // Echo rises on the following edge. That edge is BURST_DELAY+1
        // cycles after the trigger fall was seen.
        S_BURST: begin
          if (dcnt >= BURST_DELAY) begin
            echo  <= 1'b1;
            ecnt  <= ONE;
            dcnt  <= '0;
            state <= S_ECHO_HI;
          end else begin
            dcnt <= dcnt + ONE;
          end
        end

        S_ECHO_HI: begin
          if (ecnt >= wreg) begin
            echo  <= 1'b0;
            ecnt  <= '0;
            hcnt  <= ONE;
            state <= S_HOLDOFF;
          end else begin
            ecnt <= ecnt + ONE;
          end
        end

        S_HOLDOFF: begin
          if (hcnt >= HOLDOFF) begin
            hcnt  <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            hcnt <= hcnt + ONE;
          end
        end

        default: begin
          state <= S_IDLE;
          echo  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasensor_emulator.sv
// tb_ultrasensor_emulator
// Directed bench for ultrasensor_emulator with scaled-down timing parameters:
//   TRIG_MIN=10, BURST=20, TIMEOUT=100, HOLDOFF=50.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// the same point.
// After the trigger pin falls, echo is first seen high after rising edge
// number BURST+4 (2 synchronizer stages, 1 FSM cycle, then BURST+1).

module tb_ultrasensor_emulator;

  localparam int TB_W       = 16;
  localparam int TB_TRIG    = 10;
  localparam int TB_BURST   = 20;
  localparam int TB_TIMEOUT = 100;
  localparam int TB_HOLD    = 50;
  localparam int RISE_LAT   = TB_BURST + 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic            trigger = 1'b0;
  logic            obstacle_present = 1'b1;
  logic [TB_W-1:0] echo_width = '0;
  logic            echo;
  logic            busy;
  logic            short_trig;

  int n_cmp = 0;
  int n_fail = 0;
  int short_count = 0;
  int rise_count = 0;
  logic echo_prev = 1'b0;

  ultrasensor_emulator #(
    .W(TB_W),
    .TRIG_MIN_CYCLES(TB_TRIG),
    .BURST_DELAY_CYCLES(TB_BURST),
    .ECHO_TIMEOUT_CYCLES(TB_TIMEOUT),
    .HOLDOFF_CYCLES(TB_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .trigger(trigger),
    .obstacle_present(obstacle_present),
    .echo_width(echo_width),
    .echo(echo),
    .busy(busy),
    .short_trig(short_trig)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (short_trig === 1'b1) short_count++;
    if (echo === 1'b1 && echo_prev === 1'b0) rise_count++;
    echo_prev = echo;
  end

  initial begin
    if (TB_TIMEOUT >= (1 << TB_W) || TB_HOLD >= (1 << TB_W)) begin
      $display("[TB] FAIL param_fit: timing parameters do not fit in W=%0d", TB_W);
      $fatal(1, "[TB] parameter fit");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  task automatic wait_rise(output int c);
    c = 0;
    while (echo !== 1'b1 && c < 400) begin
      tick();
      c++;
    end
  endtask

  task automatic measure_echo(output int c);
    c = 0;
    while (echo === 1'b1 && c < 400) begin
      tick();
      c++;
    end
  endtask

  task automatic measure_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 400) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    n_cmp++; if (echo !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_echo: got %b expected 0", echo); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (short_trig !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_short: got %b expected 0", short_trig); end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_accept();
    int c;
    int s0;
    s0 = short_count;
    obstacle_present = 1'b1;
    echo_width = 16'd58;
    trigger = 1'b1;
    repeat (12) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_busy_trig: got %b expected 1", busy); end
    trigger = 1'b0;
    wait_rise(c);
    n_cmp++; if (c !== RISE_LAT) begin n_fail++; $display("[TB] FAIL t1_latency: got %0d expected %0d", c, RISE_LAT); end
    measure_echo(c);
    n_cmp++; if (c !== 58) begin n_fail++; $display("[TB] FAIL t1_width: got %0d expected 58", c); end
    measure_busy(c);
    n_cmp++; if (c !== TB_HOLD) begin n_fail++; $display("[TB] FAIL t1_holdoff: got %0d expected %0d", c, TB_HOLD); end
    n_cmp++; if (short_count - s0 !== 0) begin n_fail++; $display("[TB] FAIL t1_short: got %0d expected 0", short_count - s0); end
    repeat (3) tick();
  endtask

  task automatic test_short_trigger();
    int c;
    int s0;
    int r0;
    s0 = short_count;
    r0 = rise_count;
    echo_width = 16'd30;
    pulse_trigger(TB_TRIG - 1);
    repeat (10) tick();
    n_cmp++; if (short_count - s0 !== 1) begin n_fail++; $display("[TB] FAIL t2_short_pulse: got %0d expected 1", short_count - s0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t2_busy: got %b expected 0", busy); end
    n_cmp++; if (rise_count - r0 !== 0) begin n_fail++; $display("[TB] FAIL t2_no_echo: got %0d expected 0", rise_count - r0); end
    pulse_trigger(TB_TRIG);
    wait_rise(c);
    n_cmp++; if (c !== RISE_LAT) begin n_fail++; $display("[TB] FAIL t2_min_accept: got %0d expected %0d", c, RISE_LAT); end
    measure_echo(c);
    n_cmp++; if (c !== 30) begin n_fail++; $display("[TB] FAIL t2_width: got %0d expected 30", c); end
    measure_busy(c);
    repeat (3) tick();
  endtask

  task automatic test_no_obstacle();
    int c;
    obstacle_present = 1'b0;
    echo_width = 16'd5;
    pulse_trigger(12);
    wait_rise(c);
    measure_echo(c);
    n_cmp++; if (c !== TB_TIMEOUT) begin n_fail++; $display("[TB] FAIL t3_no_obstacle: got %0d expected %0d", c, TB_TIMEOUT); end
    measure_busy(c);
    repeat (3) tick();
    obstacle_present = 1'b1;
    echo_width = 16'd500;
    pulse_trigger(12);
    wait_rise(c);
    measure_echo(c);
    n_cmp++; if (c !== TB_TIMEOUT) begin n_fail++; $display("[TB] FAIL t3_clamp: got %0d expected %0d", c, TB_TIMEOUT); end
    measure_busy(c);
    repeat (3) tick();
  endtask

  task automatic test_zero_width();
    int c;
    int s0;
    int r0;
    echo_width = '0;
    pulse_trigger(12);
    wait_rise(c);
    measure_echo(c);
    n_cmp++; if (c !== 1) begin n_fail++; $display("[TB] FAIL t4_zero_width: got %0d expected 1", c); end
    s0 = short_count;
    r0 = rise_count;
    pulse_trigger(12);
    measure_busy(c);
    repeat (40) tick();
    n_cmp++; if (rise_count - r0 !== 0) begin n_fail++; $display("[TB] FAIL t4_holdoff_echo: got %0d expected 0", rise_count - r0); end
    n_cmp++; if (short_count - s0 !== 0) begin n_fail++; $display("[TB] FAIL t4_holdoff_short: got %0d expected 0", short_count - s0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_holdoff_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_echo();
    int c;
    int r0;
    echo_width = 16'd80;
    pulse_trigger(12);
    wait_rise(c);
    repeat (10) tick();
    trigger = 1'b1;
    reset = 1'b1;
    tick();
    n_cmp++; if (echo !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_echo_drop: got %b expected 0", echo); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_busy_drop: got %b expected 0", busy); end
    r0 = rise_count;
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_held_trigger: got %b expected 0", busy); end
    n_cmp++; if (rise_count - r0 !== 0) begin n_fail++; $display("[TB] FAIL t5_held_echo: got %0d expected 0", rise_count - r0); end
    trigger = 1'b0;
    repeat (3) tick();
    pulse_trigger(12);
    wait_rise(c);
    n_cmp++; if (c !== RISE_LAT) begin n_fail++; $display("[TB] FAIL t5_rerise: got %0d expected %0d", c, RISE_LAT); end
    measure_echo(c);
    n_cmp++; if (c !== 80) begin n_fail++; $display("[TB] FAIL t5_width: got %0d expected 80", c); end
    measure_busy(c);
    repeat (3) tick();
  endtask

  task automatic test_width_latch();
    int c;
    int r0;
    echo_width = 16'd58;
    pulse_trigger(12);
    repeat (10) tick();
    echo_width = 16'd10;
    wait_rise(c);
    measure_echo(c);
    n_cmp++; if (c !== 58) begin n_fail++; $display("[TB] FAIL t6_latched_width: got %0d expected 58", c); end
    measure_busy(c);
    repeat (3) tick();
    r0 = rise_count;
    pulse_trigger(12);
    repeat (10) tick();
    enable = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_enable_busy: got %b expected 0", busy); end
    enable = 1'b1;
    repeat (40) tick();
    n_cmp++; if (rise_count - r0 !== 0) begin n_fail++; $display("[TB] FAIL t6_enable_no_echo: got %0d expected 0", rise_count - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_enable_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_short_trigger();
    test_no_obstacle();
    test_zero_width();
    test_reset_mid_echo();
    test_width_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
